// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MIPS multiply/divide unit with HI/LO registers.
// Ports: clk, reset (sync, active-high); start/op/rs/rt request in;
//        busy, done (1-cycle pulse), hi, lo out. All outputs registered.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q;
  logic [W2-1:0]    acc_d;
  logic [WIDTH-1:0] opb_q;
  logic             div_q;
  logic             neg_hi_q;
  logic             neg_lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic             busy_q;
  logic             done_q;

  // Request decode and operand conditioning
  logic             is_md;
  logic             is_div;
  logic             sgn_op;
  logic             rs_neg;
  logic             rt_neg;
  logic             dz;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [WIDTH-1:0] rs_use;
  logic [W2-1:0]    acc_init;
  logic [WIDTH-1:0] opb_init;
  logic             neg_hi_init;
  logic             neg_lo_init;

  always_comb begin
    is_md  = (op <= 3'd3);
    is_div = op[1];
    sgn_op = ~op[0];
    rs_neg = sgn_op & rs[WIDTH-1];
    rt_neg = sgn_op & rt[WIDTH-1];
    dz     = is_div & (rt == '0);
    rs_mag = rs_neg ? -rs : rs;
    rt_mag = rt_neg ? -rt : rt;
    // Divide by zero runs on the raw dividend with no sign fix:
    // quotient fills with ones and the dividend shifts into the remainder.
    rs_use = dz ? rs : rs_mag;
    neg_lo_init = (rs_neg ^ rt_neg) & ~dz;
    neg_hi_init = rs_neg & ~dz;
    if (is_div) begin
      acc_init = {{WIDTH{1'b0}}, rs_use};
      opb_init = rt_mag;
    end else begin
      acc_init = {{WIDTH{1'b0}}, rt_mag};
      opb_init = rs_mag;
    end
  end

  // One iteration of shift-add or restoring shift-subtract
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;

  always_comb begin
    addend = acc_q[0] ? opb_q : '0;
    sum    = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, addend};
    rem_sh = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opb_q};
    ge     = (rem_sh >= {1'b0, opb_q});
    acc_d  = acc_q;
    if (div_q) begin
      if (ge) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;

  always_comb begin
    prod  = neg_lo_q ? -acc_q : acc_q;
    rem_w = acc_q[W2-1:WIDTH];
    quo_w = acc_q[WIDTH-1:0];
    if (div_q) begin
      hi_d = neg_hi_q ? -rem_w : rem_w;
      lo_d = neg_lo_q ? -quo_w : quo_w;
    end else begin
      hi_d = prod[W2-1:WIDTH];
      lo_d = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              is_md: begin
                acc_q    <= acc_init;
                opb_q    <= opb_init;
                div_q    <= is_div;
                neg_hi_q <= neg_hi_init;
                neg_lo_q <= neg_lo_init;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              (op == 3'd4): hi_q <= rs;
              (op == 3'd5): lo_q <= rs;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: self-checking bench for mdu_hilo.
// Vector table plus scoreboard queue, with hand-written corner sequences.
module tb_mdu_hilo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .rs   (rs),
    .rt   (rt),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  typedef struct {
    logic [31:0] eh;
    logic [31:0] el;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
    op    = o;
    rs    = a;
    rt    = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rs    = $urandom;
    rt    = $urandom;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh,
                       input logic [31:0] el);
    exp_t e;
    e.eh = eh;
    e.el = el;
    sb.push_back(e);
    start_op(o, a, b);
  endtask

  task automatic wait_result(input string nm, input int pre);
    int   cyc;
    exp_t e;
    cyc = pre;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, 64'(cyc), 64'd33);
    chk({nm, " done"}, 64'(done), 64'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty actual=0 required=1", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, " hi"}, 64'(hi), 64'(e.eh));
      chk({nm, " lo"}, 64'(lo), 64'(e.el));
    end
  endtask

  initial begin
    vec_t vt[16];
    int   dcnt;

    vt[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vt[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vt[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[5]  = '{3'd0, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vt[6]  = '{3'd0, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000000, 32'h00000020};
    vt[7]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vt[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[9]  = '{3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
    vt[10] = '{3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vt[11] = '{3'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vt[12] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vt[13] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[14] = '{3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vt[15] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    rs    = '0;
    rt    = '0;
    repeat (3) @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vt[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el);
      wait_result(nm, 0);
      @(negedge clk);
      chk({nm, " done_fall"}, 64'(done), 64'd0);
    end

    // MTHI / MTLO from idle, then ignored op codes
    start_op(3'd4, 32'h12345678, 32'h0);
    chk("mthi hi", 64'(hi), 64'h12345678);
    chk("mthi busy", 64'(busy), 64'd0);
    start_op(3'd5, 32'h0BADF00D, 32'h0);
    chk("mtlo lo", 64'(lo), 64'h0BADF00D);
    chk("mtlo done", 64'(done), 64'd0);
    start_op(3'd6, 32'hDEADBEEF, 32'h1);
    start_op(3'd7, 32'hCAFEF00D, 32'h2);
    chk("op67 hi", 64'(hi), 64'h12345678);
    chk("op67 lo", 64'(lo), 64'h0BADF00D);
    chk("op67 busy", 64'(busy), 64'd0);

    // MTLO/MTHI during a busy divide must be dropped
    issue(3'd3, 32'd1000, 32'd3, 32'd1, 32'd333);
    op    = 3'd5;
    rs    = 32'hAAAA5555;
    start = 1'b1;
    @(negedge clk);
    op    = 3'd4;
    rs    = 32'h5555AAAA;
    @(negedge clk);
    start = 1'b0;
    wait_result("mtlo_ign", 2);
    @(negedge clk);

    // Reset in the middle of a multiply
    start_op(3'd1, 32'h10, 32'h10);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("midrst no_done", 64'(dcnt), 64'd0);
    issue(3'd1, 32'd3, 32'd4, 32'd0, 32'd12);
    wait_result("after_rst", 0);
    @(negedge clk);

    // Back-to-back: second op issued in the done cycle
    issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_result("b2b_first", 0);
    issue(3'd1, 32'd6, 32'd7, 32'd0, 32'd42);
    wait_result("b2b_second", 0);
    @(negedge clk);
    chk("b2b done_fall", 64'(done), 64'd0);
    chk("sb empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
